// File: rtl/jtopl_csr_gen.sv
// Circular per-slot operator config register (LEN slots x NREG bytes) with slot-addressed masked write port.
// Latency: write commits 1..LEN cen pulses after accept, when the target slot reaches the register input.
// Backpressure: one-deep pending buffer; busy stays high until commit, and writes arriving while busy pulse wr_err.
// Optional read port enabled by defining JTOPL_CSR_RD_EN.
module jtopl_csr_gen #(
    parameter int LEN  = 18,
    parameter int NREG = 4,
    parameter int SW   = 5,
    parameter int RW   = 2
) (
    input  logic                rst,
    input  logic                clk,
    input  logic                cen,
    input  logic                wr,
    input  logic [SW-1:0]       wr_slot,
    input  logic [RW-1:0]       wr_reg,
    input  logic [7:0]          wr_mask,
    input  logic [7:0]          din,
    output logic                busy,
    output logic                wr_err,
    output logic [SW-1:0]       slot,
    output logic [8*NREG-1:0]   shift_out
`ifdef JTOPL_CSR_RD_EN
    ,
    input  logic                rd,
    input  logic [SW-1:0]       rd_slot,
    input  logic [RW-1:0]       rd_reg,
    output logic [7:0]          rd_dout,
    output logic                rd_valid
`endif
);

    localparam int W = 8 * NREG;
    localparam logic [SW:0]   LEN_C  = (SW+1)'(LEN);
    localparam logic [RW:0]   NREG_C = (RW+1)'(NREG);
    localparam logic [SW-1:0] LAST   = SW'(LEN - 1);

    logic [W-1:0]  stage [LEN];
    logic [W-1:0]  regop_in;
    logic [SW-1:0] pend_slot;
    logic [RW-1:0] pend_reg;
    logic [7:0]    pend_mask;
    logic [7:0]    pend_data;
    logic          wr_ok;
    logic          accept;
    logic          reject;
    logic          commit;

    assign shift_out = stage[LEN-1];

    // Range check is done one bit wider so LEN/NREG equal to 2**SW / 2**RW still compare correctly.
    assign wr_ok  = ({1'b0, wr_slot} < LEN_C) && ({1'b0, wr_reg} < NREG_C);
    assign accept = wr & ~busy & wr_ok;
    assign reject = wr & (busy | ~wr_ok);
    // busy is only set by accept on the following clk, so accept and commit can never coincide.
    assign commit = cen & busy & (slot == pend_slot);

    // Recirculate the outgoing word, merging the pending masked byte when its slot passes.
    always_comb begin
        regop_in = shift_out;
        for (int r = 0; r < NREG; r++) begin
            if (commit && (pend_reg == RW'(r))) begin
                regop_in[8*r +: 8] = (shift_out[8*r +: 8] & ~pend_mask) | (pend_data & pend_mask);
            end
        end
    end

    // Shift chain: stage0 takes the (possibly merged) recirculated word on every cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                stage[i] <= '0;
            end
        end else if (cen) begin
            stage[0] <= regop_in;
            for (int i = 1; i < LEN; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Slot counter tracks which slot's word is at the shift output / register input.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
        end else if (cen) begin
            slot <= (slot == LAST) ? '0 : slot + SW'(1);
        end
    end

    // Pending write buffer and busy/error handshake; runs every clk regardless of cen.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            wr_err    <= 1'b0;
            pend_slot <= '0;
            pend_reg  <= '0;
            pend_mask <= '0;
            pend_data <= '0;
        end else begin
            wr_err <= reject;
            if (accept) begin
                busy      <= 1'b1;
                pend_slot <= wr_slot;
                pend_reg  <= wr_reg;
                pend_mask <= wr_mask;
                pend_data <= din;
            end else if (commit) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef JTOPL_CSR_RD_EN
    logic          rd_pend;
    logic [SW-1:0] rd_slot_q;
    logic [RW-1:0] rd_reg_q;
    logic [7:0]    rd_byte;
    logic          rd_hit;

    assign rd_hit = cen & rd_pend & (slot == rd_slot_q);

    // Select the requested byte of the outgoing word (value before any commit merge).
    always_comb begin
        rd_byte = 8'h00;
        for (int r = 0; r < NREG; r++) begin
            if (rd_reg_q == RW'(r)) begin
                rd_byte = shift_out[8*r +: 8];
            end
        end
    end

    // Read request tracker: capture once, deliver when the slot comes around.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_slot_q <= '0;
            rd_reg_q  <= '0;
            rd_dout   <= 8'h00;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (rd_hit) begin
                rd_pend  <= 1'b0;
                rd_dout  <= rd_byte;
                rd_valid <= 1'b1;
            end else if (rd && !rd_pend) begin
                rd_pend   <= 1'b1;
                rd_slot_q <= rd_slot;
                rd_reg_q  <= rd_reg;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtopl_csr_gen.sv
// Directed bench for jtopl_csr_gen: recirculation, masked writes, rejects, cen freeze, reset cancel.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises busy/wr_err handshake including reject on the clk busy falls.
module tb_jtopl_csr_gen;
    localparam int LEN  = 18;
    localparam int NREG = 4;
    localparam int SW   = 5;
    localparam int RW   = 3;

    logic              clk;
    logic              rst;
    logic              cen;
    logic              wr;
    logic [SW-1:0]     wr_slot;
    logic [RW-1:0]     wr_reg;
    logic [7:0]        wr_mask;
    logic [7:0]        din;
    logic              busy;
    logic              wr_err;
    logic [SW-1:0]     slot;
    logic [8*NREG-1:0] shift_out;
`ifdef JTOPL_CSR_RD_EN
    logic              rd;
    logic [SW-1:0]     rd_slot;
    logic [RW-1:0]     rd_reg;
    logic [7:0]        rd_dout;
    logic              rd_valid;
`endif

    int          npass;
    int          ntotal;
    int          nfail;
    int          exp_slot;
    logic [31:0] model [LEN];

    jtopl_csr_gen #(.LEN(LEN), .NREG(NREG), .SW(SW), .RW(RW)) dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .wr        (wr),
        .wr_slot   (wr_slot),
        .wr_reg    (wr_reg),
        .wr_mask   (wr_mask),
        .din       (din),
        .busy      (busy),
        .wr_err    (wr_err),
        .slot      (slot),
        .shift_out (shift_out)
`ifdef JTOPL_CSR_RD_EN
        ,
        .rd        (rd),
        .rd_slot   (rd_slot),
        .rd_reg    (rd_reg),
        .rd_dout   (rd_dout),
        .rd_valid  (rd_valid)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntotal++;
        assert (got === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock; the expected slot follows the sync reset / cen seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) exp_slot = 0;
        else if (cen) exp_slot = (exp_slot + 1) % LEN;
        #1;
    endtask

    task automatic goto_slot(input int k);
        for (int n = 0; n < 2*LEN && exp_slot != k; n++) tick();
    endtask

    task automatic check_lap();
        for (int n = 0; n < LEN; n++) begin
            chk("lap_slot", 32'(slot), 32'(exp_slot));
            chk("lap_word", shift_out, model[exp_slot]);
            tick();
        end
    endtask

    task automatic issue_wr(input int s, input int r, input logic [7:0] m, input logic [7:0] d);
        wr = 1'b1; wr_slot = SW'(s); wr_reg = RW'(r); wr_mask = m; din = d;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        npass = 0; ntotal = 0; nfail = 0; exp_slot = 0;
        for (int i = 0; i < LEN; i++) model[i] = 32'h0;
        rst = 1'b1; cen = 1'b0; wr = 1'b0; wr_slot = '0; wr_reg = '0; wr_mask = '0; din = '0;
`ifdef JTOPL_CSR_RD_EN
        rd = 1'b0; rd_slot = '0; rd_reg = '0;
`endif
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        chk("rst_word", shift_out, 32'h0);
        rst = 1'b0; cen = 1'b1;

        // Idle recirculation for two laps.
        for (int n = 0; n < 2*LEN; n++) begin
            chk("idle_slot", 32'(slot), 32'(n % LEN));
            chk("idle_word", shift_out, 32'h0);
            tick();
        end

        // Full-byte write to slot 5 lane 1.
        issue_wr(5, 1, 8'hFF, 8'hA5);
        chk("wr5_err", 32'(wr_err), 32'h0);
        chk("wr5_busy", 32'(busy), 32'h1);
        goto_slot(5);
        chk("wr5_busy_hold", 32'(busy), 32'h1);
        tick();
        chk("wr5_busy_clr", 32'(busy), 32'h0);
        model[5] = 32'h0000A500;
        check_lap();

        // Preload slot 3 lane 0 then masked low-nibble update.
        issue_wr(3, 0, 8'hFF, 8'hF0);
        goto_slot(3);
        tick();
        model[3] = 32'h000000F0;
        issue_wr(3, 0, 8'h0F, 8'h0A);
        chk("mask_busy", 32'(busy), 32'h1);
        goto_slot(3);
        tick();
        chk("mask_busy_clr", 32'(busy), 32'h0);
        model[3] = 32'h000000FA;
        check_lap();

        // Reject while busy, then reject on the clk busy falls.
        issue_wr(7, 2, 8'hFF, 8'h3C);
        chk("rej_first_busy", 32'(busy), 32'h1);
        chk("rej_first_err", 32'(wr_err), 32'h0);
        issue_wr(8, 0, 8'hFF, 8'hEE);
        chk("rej_busy_err", 32'(wr_err), 32'h1);
        tick();
        chk("rej_busy_pulse", 32'(wr_err), 32'h0);
        goto_slot(7);
        chk("fall_busy_pre", 32'(busy), 32'h1);
        issue_wr(9, 0, 8'hFF, 8'h11);
        chk("fall_err", 32'(wr_err), 32'h1);
        chk("fall_busy", 32'(busy), 32'h0);
        model[7] = 32'h003C0000;
        tick();
        chk("fall_pulse", 32'(wr_err), 32'h0);

        // Out-of-range slot and byte index.
        issue_wr(18, 0, 8'hFF, 8'h99);
        chk("rej_slot_err", 32'(wr_err), 32'h1);
        chk("rej_slot_busy", 32'(busy), 32'h0);
        tick();
        chk("rej_slot_pulse", 32'(wr_err), 32'h0);
        issue_wr(2, 4, 8'hFF, 8'h99);
        chk("rej_reg_err", 32'(wr_err), 32'h1);
        chk("rej_reg_busy", 32'(busy), 32'h0);
        tick();
        chk("rej_reg_pulse", 32'(wr_err), 32'h0);
        check_lap();

        // Freeze with cen low while a write is pending.
        cen = 1'b0;
        issue_wr(12, 3, 8'hFF, 8'h5A);
        for (int n = 0; n < 50; n++) begin
            chk("frz_busy", 32'(busy), 32'h1);
            chk("frz_slot", 32'(slot), 32'(exp_slot));
            tick();
        end
        cen = 1'b1;
        goto_slot(12);
        chk("frz_busy_pre", 32'(busy), 32'h1);
        tick();
        chk("frz_busy_clr", 32'(busy), 32'h0);
        model[12] = 32'h5A000000;
        check_lap();

        // Reset while a write to slot 10 is pending.
        goto_slot(11);
        issue_wr(10, 0, 8'hFF, 8'h77);
        tick();
        chk("rc_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rc_busy", 32'(busy), 32'h0);
        chk("rc_slot", 32'(slot), 32'h0);
        chk("rc_err", 32'(wr_err), 32'h0);
        for (int i = 0; i < LEN; i++) model[i] = 32'h0;
        check_lap();

`ifdef JTOPL_CSR_RD_EN
        chk("rd_rst_valid", 32'(rd_valid), 32'h0);
        rd = 1'b1; rd_slot = SW'(10); rd_reg = '0;
        tick();
        rd = 1'b0;
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 2*LEN && !seen; n++) begin
                if (rd_valid) seen = 1'b1;
                else tick();
            end
            chk("rd_seen", 32'(seen), 32'h1);
            chk("rd_dout", 32'(rd_dout), 32'h0);
            tick();
            chk("rd_pulse", 32'(rd_valid), 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
